// File: rtl/rom_pkg.sv
// Shared ROM geometry and the owner tag carried alongside each in-flight read.
package rom_pkg;

  localparam int ROM_ADDR_W  = 11;
  localparam int ROM_WORD_W  = 9;
  localparam int ROM_LATENCY = 2;

  typedef enum logic {
    PORT_FETCH = 1'b0,
    PORT_DATA  = 1'b1
  } port_e;

  typedef struct packed {
    logic  valid;
    port_e owner;
  } tag_t;

endpackage

// File: rtl/rom_tag_pipe.sv
// Shift register of {valid, owner} tags that tracks reads through the ROM's
// fixed latency; an asynchronous clear drops every read still in flight.
module rom_tag_pipe
  import rom_pkg::*;
#(
  parameter int Depth = ROM_LATENCY
) (
  input  logic clk,
  input  logic rst_n,
  input  logic in_valid,
  input  logic in_owner,
  output logic out_valid,
  output logic out_owner
);

  tag_t stage [Depth];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < Depth; i++) begin
        stage[i] <= '0;
      end
    end else begin
      stage[0] <= '{valid: in_valid, owner: port_e'(in_owner)};
      for (int i = 1; i < Depth; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out_valid = stage[Depth-1].valid;
  assign out_owner = stage[Depth-1].owner;

endmodule

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one synchronous ROM between the fetch port (0)
// and the data-load port (1), returning each word only to its issuer.
module rom_arbiter
  import rom_pkg::*;
#(
  parameter int AddrSize = ROM_ADDR_W,
  parameter int WordSize = ROM_WORD_W,
  parameter int Latency  = ROM_LATENCY
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req0,
  input  logic [AddrSize-1:0] addr0,
  output logic                gnt0,
  output logic                rvalid0,
  output logic [WordSize-1:0] rdata0,
  input  logic                req1,
  input  logic [AddrSize-1:0] addr1,
  output logic                gnt1,
  output logic                rvalid1,
  output logic [WordSize-1:0] rdata1,
  output logic [AddrSize-1:0] rom_addr,
  output logic                rom_en,
  input  logic [WordSize-1:0] rom_do
);

  // Handshake: reqN is a level held until gntN; a read transfers in every
  // cycle where reqN && gntN. The return side has no ready: rvalidN must be
  // accepted in the cycle it is high.
  port_e prio;
  logic  ret_valid;
  logic  ret_owner;

  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      gnt0 = req0 && (!req1 || prio == PORT_FETCH);
      gnt1 = req1 && (!req0 || prio == PORT_DATA);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio <= PORT_FETCH;
    end else if (gnt0) begin
      prio <= PORT_DATA;
    end else if (gnt1) begin
      prio <= PORT_FETCH;
    end
  end

  always_comb begin
    rom_en   = gnt0 | gnt1;
    rom_addr = '0;
    if (gnt0) begin
      rom_addr = addr0;
    end else if (gnt1) begin
      rom_addr = addr1;
    end
  end

  // The owner of a granted read is simply gnt1, since at most one grant is high.
  rom_tag_pipe #(
    .Depth(Latency)
  ) u_tag_pipe (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (rom_en),
    .in_owner (gnt1),
    .out_valid(ret_valid),
    .out_owner(ret_owner)
  );

  // Masking keeps the ROM's Z after a disabled read off both data buses.
  always_comb begin
    rvalid0 = ret_valid && (port_e'(ret_owner) == PORT_FETCH);
    rvalid1 = ret_valid && (port_e'(ret_owner) == PORT_DATA);
    rdata0  = rvalid0 ? rom_do : '0;
    rdata1  = rvalid1 ? rom_do : '0;
  end

endmodule

// File: tb/tb_rom_arbiter.sv
// Directed bench for rom_arbiter with a 2-cycle synchronous ROM model that
// drives Z after a disabled read.
module tb_rom_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0 = 1'b0;
  logic [10:0] addr0 = '0;
  logic        gnt0;
  logic        rvalid0;
  logic [8:0]  rdata0;
  logic        req1 = 1'b0;
  logic [10:0] addr1 = '0;
  logic        gnt1;
  logic        rvalid1;
  logic [8:0]  rdata1;
  logic [10:0] rom_addr;
  logic        rom_en;
  wire  [8:0]  rom_do;

  int tests = 0;
  int failed = 0;
  string step = "reset";

  // Expected return entries {grant0, grant1, addr}; the front is two cycles old.
  logic [12:0] exp_q[$];

  always #5 clk = ~clk;

  rom_arbiter dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req0    (req0),
    .addr0   (addr0),
    .gnt0    (gnt0),
    .rvalid0 (rvalid0),
    .rdata0  (rdata0),
    .req1    (req1),
    .addr1   (addr1),
    .gnt1    (gnt1),
    .rvalid1 (rvalid1),
    .rdata1  (rdata1),
    .rom_addr(rom_addr),
    .rom_en  (rom_en),
    .rom_do  (rom_do)
  );

  function automatic logic [8:0] rom_word(input logic [10:0] a);
    if (a == 11'd5) return 9'h1A3;
    return 9'(a * 7) ^ 9'h0AA;
  endfunction

  logic        p1_en = 1'b0, p2_en = 1'b0;
  logic [10:0] p1_a = '0, p2_a = '0;

  always @(posedge clk) begin
    p1_en <= rom_en;
    p1_a  <= rom_addr;
    p2_en <= p1_en;
    p2_a  <= p1_a;
  end

  assign rom_do = p2_en ? rom_word(p2_a) : 9'bz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s/%s observed=0x%0h expected=0x%0h", step, tag, obs, exp);
    end
  endtask

  task automatic cyc(input logic r0, input logic [10:0] a0, input logic r1,
                     input logic [10:0] a1, input logic eg0, input logic eg1);
    logic [12:0] ent;
    logic [10:0] ea;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    req0  = r0;
    addr0 = a0;
    req1  = r1;
    addr1 = a1;
    #1;
    ea = eg0 ? a0 : (eg1 ? a1 : 11'd0);
    exp_q.push_back({eg0, eg1, ea});
    ent = exp_q.pop_front();
    chk("gnt0", 32'(gnt0), 32'(eg0));
    chk("gnt1", 32'(gnt1), 32'(eg1));
    chk("rom_en", 32'(rom_en), 32'(eg0 | eg1));
    chk("rom_addr", 32'(rom_addr), 32'(ea));
    chk("rvalid0", 32'(rvalid0), 32'(ent[12]));
    chk("rdata0", 32'(rdata0), ent[12] ? 32'(rom_word(ent[10:0])) : 32'd0);
    chk("rvalid1", 32'(rvalid1), 32'(ent[11]));
    chk("rdata1", 32'(rdata1), ent[11] ? 32'(rom_word(ent[10:0])) : 32'd0);
  endtask

  task automatic rst_cyc(input logic r0, input logic [10:0] a0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req0  = r0;
    addr0 = a0;
    req1  = r0;
    addr1 = a0;
    #1;
    chk("rst_gnt0", 32'(gnt0), 32'd0);
    chk("rst_gnt1", 32'(gnt1), 32'd0);
    chk("rst_rom_en", 32'(rom_en), 32'd0);
    chk("rst_rom_addr", 32'(rom_addr), 32'd0);
    chk("rst_rvalid0", 32'(rvalid0), 32'd0);
    chk("rst_rvalid1", 32'(rvalid1), 32'd0);
    chk("rst_rdata0", 32'(rdata0), 32'd0);
    chk("rst_rdata1", 32'(rdata1), 32'd0);
    exp_q = '{13'd0, 13'd0};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_q = '{13'd0, 13'd0};

    // Reset held with requests pending: nothing may be granted.
    step = "reset";
    for (int i = 0; i < 3; i++) rst_cyc(1'b1, 11'h005);

    // Single read of ROM[5] on port 0.
    step = "single";
    cyc(1'b1, 11'h005, 1'b0, 11'h000, 1'b1, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    // Port 1 alone moves prio back to 0, so contention then favours port 0.
    step = "prio_hold";
    cyc(1'b0, 11'h000, 1'b1, 11'h002, 1'b0, 1'b1);
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b1, 1'b0);
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b0, 1'b1);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    // Constant contention alternates 0,1,0,1.
    step = "contention";
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b1, 1'b0);
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b0, 1'b1);
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b1, 1'b0);
    cyc(1'b1, 11'h001, 1'b1, 11'h002, 1'b0, 1'b1);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    // Back-to-back reads on port 1 at the top of the address space.
    step = "stream";
    for (int i = 0; i < 8; i++) cyc(1'b0, 11'h000, 1'b1, 11'(11'h7F8 + i), 1'b0, 1'b1);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    // Idle: ROM drives Z, outputs must stay masked to zero.
    step = "idle";
    for (int i = 0; i < 5; i++) cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    // Reset one cycle after a grant discards that read and restores prio = 0.
    step = "reset_mid";
    cyc(1'b1, 11'h003, 1'b0, 11'h000, 1'b1, 1'b0);
    rst_cyc(1'b0, 11'h000);
    cyc(1'b1, 11'h004, 1'b1, 11'h006, 1'b1, 1'b0);
    cyc(1'b0, 11'h000, 1'b1, 11'h006, 1'b0, 1'b1);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);
    cyc(1'b0, 11'h000, 1'b0, 11'h000, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
